// File: rtl/demux41_seq.sv
`default_nettype none
// demux41_seq: routes a serial bit to one of four registered outputs.
// Tracks frames of four writes and flags overwrites in addressed mode.
module demux41_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic [1:0] sel,
  input  logic       mode,
  input  logic       clr,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       frame_valid,
  output logic       err,
  output logic [3:0] slot_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] data_q, data_d;  // bit index equals slot code: bit3 = a
  logic [3:0] mask_q, mask_d;
  logic [1:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       fv_q, fv_d;
  logic       mode_q;

  logic [1:0] tgt;
  logic [3:0] onehot;
  logic [3:0] base_mask;
  logic [3:0] new_mask;

  always_comb begin
    tgt       = mode ? cnt_q : sel;
    onehot    = 4'b0001 << tgt;
    // A write in DONE opens a new frame, so the previous mask does not count.
    base_mask = (state_q == DONE) ? 4'b0000 : mask_q;
    new_mask  = base_mask | onehot;

    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = 1'b0;

    if (clr) begin
      state_d = IDLE;
      mask_d  = 4'b0000;
      cnt_d   = 2'd3;
      err_d   = 1'b0;
    end else if (mode != mode_q) begin
      state_d = IDLE;
      mask_d  = 4'b0000;
      cnt_d   = 2'd3;
    end else if (din_valid) begin
      data_d[tgt] = din;
      if (mode) begin
        cnt_d = cnt_q - 2'd1;
      end
      if (!mode && ((base_mask & onehot) != 4'b0000)) begin
        err_d = 1'b1;
      end else if (new_mask == 4'b1111) begin
        state_d = DONE;
        mask_d  = 4'b0000;
        fv_d    = 1'b1;
      end else begin
        state_d = FILL;
        mask_d  = new_mask;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 4'b0000;
      mask_q  <= 4'b0000;
      cnt_q   <= 2'd3;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      mode_q  <= mode;
    end
  end

  assign a           = data_q[3];
  assign b           = data_q[2];
  assign c           = data_q[1];
  assign d           = data_q[0];
  assign frame_valid = fv_q;
  assign err         = err_q;
  assign slot_mask   = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_demux41_seq.sv
`default_nettype none
// Scoreboard bench for demux41_seq: frames are queued by the stimulus and
// popped by a monitor on every frame_valid pulse.
module tb_demux41_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       mode = 1'b0;
  logic       clr = 1'b0;
  logic       a, b, c, d, frame_valid, err;
  logic [3:0] slot_mask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] abcd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  demux41_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sel        (sel),
    .mode       (mode),
    .clr        (clr),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .frame_valid(frame_valid),
    .err        (err),
    .slot_mask  (slot_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit dv, input bit dn, input logic [1:0] s);
    din_valid = dv;
    din       = dn;
    sel       = s;
    @(posedge clk);
    #1;
  endtask

  // Called right after the write that completes a frame.
  task automatic expect_frame(input logic [3:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.abcd = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("frame_cycle", cyc, mon_e.cyc);
        chk("frame_abcd", int'({a, b, c, d}), int'(mon_e.abcd));
        chk("frame_mask", int'(slot_mask), 0);
        chk("frame_err", int'(err), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Back-to-back frame contents for din = (i % 3 == 0), i = 0..11.
  logic [3:0] b2b_exp [3] = '{4'b1001, 4'b0010, 4'b0100};

  initial begin
    // Reset state
    #12;
    chk("rst_abcd", int'({a, b, c, d}), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_mask", int'(slot_mask), 0);
    rst_n = 1'b1;

    // Addressed frame: d=1, c=1, a=0, b=1
    mode = 1'b0;
    step(1, 1, 2'b00);
    step(1, 1, 2'b01);
    chk("addr_mask_2w", int'(slot_mask), 4'b0011);
    step(1, 0, 2'b11);
    step(1, 1, 2'b10);
    expect_frame(4'b0111);
    step(0, 0, 2'b00);
    chk("addr_hold_abcd", int'({a, b, c, d}), 4'b0111);

    // Addressed overwrite of a
    step(1, 0, 2'b11);
    chk("ovw_mask_1", int'(slot_mask), 4'b1000);
    chk("ovw_a_1", int'(a), 0);
    step(1, 1, 2'b11);
    chk("ovw_a_2", int'(a), 1);
    chk("ovw_err", int'(err), 1);
    chk("ovw_mask_2", int'(slot_mask), 4'b1000);
    step(0, 0, 2'b00);
    chk("ovw_err_sticky", int'(err), 1);
    clr = 1'b1;
    step(1, 0, 2'b11);
    clr = 1'b0;
    chk("clr_err", int'(err), 0);
    chk("clr_mask", int'(slot_mask), 0);
    chk("clr_a_hold", int'(a), 1);

    // Auto frame: din 1,0,1,1 -> a=1 b=0 c=1 d=1
    mode = 1'b1;
    step(0, 0, 2'b00);
    step(1, 1, 2'b00);
    step(1, 0, 2'b00);
    chk("auto_mask_2w", int'(slot_mask), 4'b1100);
    step(1, 1, 2'b00);
    step(1, 1, 2'b00);
    expect_frame(4'b1011);
    step(0, 0, 2'b00);

    // Mode toggle mid-frame discards the write
    step(1, 0, 2'b00);
    step(1, 0, 2'b00);
    chk("mchg_mask_pre", int'(slot_mask), 4'b1100);
    mode = 1'b0;
    step(1, 1, 2'b00);
    chk("mchg_abcd_hold", int'({a, b, c, d}), 4'b0011);
    chk("mchg_mask", int'(slot_mask), 0);
    mode = 1'b1;
    step(0, 0, 2'b00);
    step(1, 0, 2'b00);
    chk("mchg_restart_a", int'(slot_mask), 4'b1000);
    step(1, 1, 2'b00);
    step(1, 0, 2'b00);
    step(1, 0, 2'b00);
    expect_frame(4'b0100);
    step(0, 0, 2'b00);

    // Asynchronous reset mid-frame
    step(1, 1, 2'b00);
    step(1, 1, 2'b00);
    step(1, 1, 2'b00);
    chk("arst_mask_pre", int'(slot_mask), 4'b1110);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_abcd", int'({a, b, c, d}), 0);
    chk("arst_mask", int'(slot_mask), 0);
    chk("arst_fv", int'(frame_valid), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 2'b00);
    step(1, 0, 2'b00);
    chk("arst_fresh_a", int'(slot_mask), 4'b1000);
    step(1, 0, 2'b00);
    step(1, 0, 2'b00);
    step(1, 1, 2'b00);
    expect_frame(4'b0001);
    step(0, 0, 2'b00);

    // Back-to-back frames, din_valid high for 12 cycles
    for (int i = 0; i < 12; i++) begin
      step(1, (i % 3) == 0, 2'b00);
      if ((i % 4) == 3) expect_frame(b2b_exp[i / 4]);
    end
    step(0, 0, 2'b00);
    step(0, 0, 2'b00);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
